// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// Latency: 1 clk from the internal cnt/idx/active state to seg/dp/an/frame_tick.
// Backpressure: none; load is always accepted and the latest load before a frame boundary wins.
//
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   value        packed hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_in        per-digit decimal point request, 1 = lit
//   blank        per-digit force-dark, 1 = dark
//   load         capture value/dp_in/blank into the holding register
//   seg          active-low segments {g,f,e,d,c,b,a}
//   dp           active-low decimal point
//   an           active-low anode enables, at most one bit low
//   frame_tick   1-cycle pulse the cycle after the scan wraps from digit N-1 to 0
//
// Optional feature: define SEG7_LZB_EN to enable leading-zero blanking
// (digit i>0 goes dark when it and every more-significant nibble are zero).

module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int GUARD      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);

  // Scan position
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          cnt_wrap;
  logic          frame_end;

  // Holding (written by load) and active (displayed) buffers
  logic [4*NUM_DIGITS-1:0] hold_value;
  logic [NUM_DIGITS-1:0]   hold_dp;
  logic [NUM_DIGITS-1:0]   hold_blank;
  logic                    pending;

  logic [4*NUM_DIGITS-1:0] act_value;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;

  // Decode
  logic                  in_window;
  logic [NUM_DIGITS-1:0] lz_dark;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  assign cnt_wrap  = (cnt == CNT_LAST);
  // With a single digit idx never moves, so every cnt wrap ends a frame.
  assign frame_end = cnt_wrap && (idx == IDX_LAST);

  // ------------------------------------------------------------------
  // Slot counter and digit index
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (cnt_wrap) begin
        cnt <= '0;
        if (idx == IDX_LAST) begin
          idx <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Double buffer. The active word only changes on the frame boundary,
  // so a frame never shows a mix of old and new digits. A load that lands
  // on the boundary cycle itself bypasses holding and becomes active at once.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_value <= '0;
      hold_dp    <= '0;
      hold_blank <= '0;
      pending    <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      if (load) begin
        hold_value <= value;
        hold_dp    <= dp_in;
        hold_blank <= blank;
      end

      if (load && frame_end) begin
        act_value <= value;
        act_dp    <= dp_in;
        act_blank <= blank;
        pending   <= 1'b0;
      end else if (load) begin
        pending   <= 1'b1;
      end else if (frame_end && pending) begin
        act_value <= hold_value;
        act_dp    <= hold_dp;
        act_blank <= hold_blank;
        pending   <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Dead-time guard: the first GUARD clocks of each slot stay dark so the
  // previous digit's segments cannot ghost onto the newly enabled anode.
  // ------------------------------------------------------------------
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_window = 1'b1;
    end else begin : g_guard
      assign in_window = (cnt >= GUARD_CNT);
    end
  endgenerate

  // ------------------------------------------------------------------
  // Leading-zero suppression
  // ------------------------------------------------------------------
`ifdef SEG7_LZB_EN
  logic lz_run;

  // Walk from the most significant digit down; a digit is suppressed while
  // it and everything above it are zero. Digit 0 always shows.
  always_comb begin
    lz_dark = '0;
    lz_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run     = lz_run & (act_value[4*i +: 4] == 4'h0);
      lz_dark[i] = lz_run;
    end
  end
`else
  assign lz_dark = '0;
`endif

  // ------------------------------------------------------------------
  // Glyph table, active-low {g,f,e,d,c,b,a}
  // ------------------------------------------------------------------
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h18;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  endfunction

  // ------------------------------------------------------------------
  // Per-digit decode. Looping over digits rather than indexing by idx keeps
  // every select in range when NUM_DIGITS is not a power of two.
  // ------------------------------------------------------------------
  always_comb begin
    an_nxt  = '1;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (in_window && (idx == IW'(i)) && !act_blank[i] && !lz_dark[i]) begin
        an_nxt[i] = 1'b0;
        seg_nxt   = glyph(act_value[4*i +: 4]);
        dp_nxt    = ~act_dp[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Registered pin drivers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_tick <= frame_end;
    end
  end

endmodule
